// File: rtl/perfc_multi_pkg.sv
// Shared definitions for the multi-channel performance counter:
// register offsets, CFG field layout and the channel config bundle.
package perfc_multi_pkg;

  localparam logic [31:0] OFF_CTRL        = 32'h00;
  localparam logic [31:0] OFF_INTR_STATE  = 32'h04;
  localparam logic [31:0] OFF_INTR_ENABLE = 32'h08;
  localparam logic [31:0] CNT_BASE        = 32'h20;
  localparam logic [31:0] CNT_STRIDE      = 32'h20;

  localparam logic [4:0] SUB_CFG     = 5'h00;
  localparam logic [4:0] SUB_CNT_LO  = 5'h04;
  localparam logic [4:0] SUB_CNT_HI  = 5'h08;
  localparam logic [4:0] SUB_SNAP_LO = 5'h0C;
  localparam logic [4:0] SUB_SNAP_HI = 5'h10;

  localparam int CTRL_GEN  = 0;
  localparam int CTRL_SNAP = 1;
  localparam int CTRL_CLR  = 2;

  localparam int CFG_EN       = 0;
  localparam int CFG_MODE     = 1;
  localparam int CFG_EVSEL_LO = 8;
  localparam int CFG_EVSEL_HI = 12;

  typedef struct packed {
    logic       en;
    logic       mode;
    logic [4:0] evsel;
  } cfg_t;

  function automatic logic [31:0] cfg_word(cfg_t c);
    logic [31:0] w;
    w = '0;
    w[CFG_EN] = c.en;
    w[CFG_MODE] = c.mode;
    w[CFG_EVSEL_HI:CFG_EVSEL_LO] = c.evsel;
    return w;
  endfunction

  function automatic cfg_t word_cfg(logic [31:0] w);
    cfg_t c;
    c.en = w[CFG_EN];
    c.mode = w[CFG_MODE];
    c.evsel = w[CFG_EVSEL_HI:CFG_EVSEL_LO];
    return c;
  endfunction

endpackage

// File: rtl/reg_pkg.sv
// Peripheral-subsystem register bus request/response types.
// One 32-bit word per access; ready is always asserted by slaves.
package reg_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

// File: rtl/perfc_channel.sv
// One counter channel: event select, level/edge hit, counter,
// snapshot register and wrap pulse.
module perfc_channel
  import perfc_multi_pkg::*;
#(
  parameter int NUM_EVT   = 16,
  parameter int CNT_WIDTH = 48
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  cfg_t                 i_cfg,
  input  logic                 i_gen,
  input  logic [NUM_EVT-1:0]   i_events,
  input  logic                 i_clr,
  input  logic                 i_snap,
  input  logic                 i_wr_lo,
  input  logic                 i_wr_hi,
  input  logic [31:0]          i_wdata,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic [CNT_WIDTH-1:0] o_snap_val,
  output logic                 o_wrap
);

  localparam int HW = CNT_WIDTH - 32;
  localparam logic [CNT_WIDTH-1:0] ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_EVT-1:0]   r_prev;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_snap;

  logic [31:0] w_ev;
  logic [31:0] w_pv;
  logic        w_sel_ok;
  logic        w_lvl;
  logic        w_old;
  logic        w_hit;
  logic        w_inc;
  logic        w_wr;

  assign w_ev = 32'(i_events);
  assign w_pv = 32'(r_prev);
  assign w_sel_ok = 32'(i_cfg.evsel) < 32'(NUM_EVT);
  assign w_lvl = w_ev[i_cfg.evsel];
  assign w_old = w_pv[i_cfg.evsel];
  assign w_hit = w_sel_ok &
    (i_cfg.mode ? (w_lvl & ~w_old) : w_lvl);
  assign w_inc = i_gen & i_cfg.en & w_hit;
  assign w_wr = i_wr_lo | i_wr_hi;

  // A clear or software write swallows the increment, so no wrap either.
  assign o_wrap = w_inc & (&r_cnt) & ~i_clr & ~w_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prev <= '0;
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      r_prev <= i_events;
      if (i_snap) r_snap <= r_cnt;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_wr_lo) begin
        r_cnt[31:0] <= i_wdata;
      end else if (i_wr_hi) begin
        r_cnt[CNT_WIDTH-1:32] <= i_wdata[HW-1:0];
      end else if (w_inc) begin
        r_cnt <= r_cnt + ONE;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_snap_val = r_snap;

endmodule

// File: rtl/perfc_multi.sv
// Multi-channel performance counter peripheral: register decode,
// global control, split-read shadows and level interrupt.
module perfc_multi
  import perfc_multi_pkg::*;
#(
  parameter int  NUM_CNT   = 4,
  parameter int  NUM_EVT   = 16,
  parameter int  CNT_WIDTH = 48,
  parameter type reg_req_t = reg_pkg::reg_req_t,
  parameter type reg_rsp_t = reg_pkg::reg_rsp_t
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  reg_req_t           reg_req_i,
  output reg_rsp_t           reg_rsp_o,
  input  logic [NUM_EVT-1:0] events_i,
  output logic               intr_o
);

  localparam logic [31:0] CNT_END =
    CNT_BASE + CNT_STRIDE * 32'(NUM_CNT);

  logic               r_gen;
  logic [NUM_CNT-1:0] r_ist;
  logic [NUM_CNT-1:0] r_ien;
  logic [31:0]        r_hi_sh;
  logic [31:0]        r_snap_sh;
  cfg_t               r_cfg [NUM_CNT];

  logic [CNT_WIDTH-1:0] w_cnt  [NUM_CNT];
  logic [CNT_WIDTH-1:0] w_snapv[NUM_CNT];
  logic [NUM_CNT-1:0]   w_wrap;
  logic [NUM_CNT-1:0]   w_sel;
  logic [CNT_WIDTH-1:0] w_cnt_sel;
  logic [CNT_WIDTH-1:0] w_snap_sel;
  cfg_t                 w_cfg_sel;

  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [7:0]  w_rel;
  logic [2:0]  w_idx;
  logic [4:0]  w_sub;
  logic        w_in_cnt;
  logic        w_is_ctrl;
  logic        w_is_ist;
  logic        w_is_ien;
  logic        w_s_cfg;
  logic        w_s_lo;
  logic        w_s_hi;
  logic        w_s_slo;
  logic        w_s_shi;
  logic        w_map;
  logic        w_rd;
  logic        w_wr;
  logic        w_err;
  logic        w_ctrl_wr;
  logic        w_snap;
  logic        w_clr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^reg_req_i.wstrb;

  assign w_addr  = reg_req_i.addr;
  assign w_wdata = reg_req_i.wdata;
  assign w_rel   = 8'(w_addr - CNT_BASE);
  assign w_idx   = w_rel[7:5];
  assign w_sub   = w_rel[4:0];

  assign w_in_cnt  = (w_addr >= CNT_BASE) && (w_addr < CNT_END);
  assign w_is_ctrl = w_addr == OFF_CTRL;
  assign w_is_ist  = w_addr == OFF_INTR_STATE;
  assign w_is_ien  = w_addr == OFF_INTR_ENABLE;
  assign w_s_cfg   = w_in_cnt && (w_sub == SUB_CFG);
  assign w_s_lo    = w_in_cnt && (w_sub == SUB_CNT_LO);
  assign w_s_hi    = w_in_cnt && (w_sub == SUB_CNT_HI);
  assign w_s_slo   = w_in_cnt && (w_sub == SUB_SNAP_LO);
  assign w_s_shi   = w_in_cnt && (w_sub == SUB_SNAP_HI);

  assign w_map = w_is_ctrl | w_is_ist | w_is_ien |
    w_s_cfg | w_s_lo | w_s_hi | w_s_slo | w_s_shi;

  assign w_rd  = reg_req_i.valid & ~reg_req_i.write & w_map;
  assign w_wr  = reg_req_i.valid &  reg_req_i.write & w_map;
  assign w_err = reg_req_i.valid & ~w_map;

  assign w_ctrl_wr = w_wr & w_is_ctrl;
  assign w_snap = w_ctrl_wr & w_wdata[CTRL_SNAP];
  assign w_clr  = w_ctrl_wr & w_wdata[CTRL_CLR];

  always_comb begin
    w_sel = '0;
    w_cnt_sel = '0;
    w_snap_sel = '0;
    w_cfg_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (w_in_cnt && (w_idx == 3'(i))) begin
        w_sel[i] = 1'b1;
        w_cnt_sel = w_cnt[i];
        w_snap_sel = w_snapv[i];
        w_cfg_sel = r_cfg[i];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_is_ctrl: w_rdata = {31'b0, r_gen};
      w_is_ist:  w_rdata = 32'(r_ist);
      w_is_ien:  w_rdata = 32'(r_ien);
      w_s_cfg:   w_rdata = cfg_word(w_cfg_sel);
      w_s_lo:    w_rdata = w_cnt_sel[31:0];
      w_s_hi:    w_rdata = r_hi_sh;
      w_s_slo:   w_rdata = w_snap_sel[31:0];
      w_s_shi:   w_rdata = r_snap_sh;
      default:   w_rdata = '0;
    endcase
  end

  always_comb begin
    reg_rsp_o = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.rdata = w_rd ? w_rdata : 32'h0;
    reg_rsp_o.error = w_err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gen <= 1'b0;
      r_ist <= '0;
      r_ien <= '0;
      r_hi_sh <= '0;
      r_snap_sh <= '0;
      for (int i = 0; i < NUM_CNT; i++) r_cfg[i] <= '0;
    end else begin
      if (w_ctrl_wr) r_gen <= w_wdata[CTRL_GEN];
      // Wrap set is OR-ed in after the W1C mask so set wins.
      r_ist <= (r_ist & ~((w_wr & w_is_ist) ?
        w_wdata[NUM_CNT-1:0] : '0)) | w_wrap;
      if (w_wr & w_is_ien) r_ien <= w_wdata[NUM_CNT-1:0];
      if (w_rd & w_s_lo)
        r_hi_sh <= 32'(w_cnt_sel[CNT_WIDTH-1:32]);
      if (w_rd & w_s_slo)
        r_snap_sh <= 32'(w_snap_sel[CNT_WIDTH-1:32]);
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_wr & w_s_cfg & w_sel[i]) r_cfg[i] <= word_cfg(w_wdata);
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ch
    perfc_channel #(
      .NUM_EVT  (NUM_EVT),
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_cfg     (r_cfg[g]),
      .i_gen     (r_gen),
      .i_events  (events_i),
      .i_clr     (w_clr),
      .i_snap    (w_snap),
      .i_wr_lo   (w_wr & w_s_lo & w_sel[g]),
      .i_wr_hi   (w_wr & w_s_hi & w_sel[g]),
      .i_wdata   (w_wdata),
      .o_cnt     (w_cnt[g]),
      .o_snap_val(w_snapv[g]),
      .o_wrap    (w_wrap[g])
    );
  end

  assign intr_o = |(r_ist & r_ien);

endmodule

// File: tb/tb_perfc_multi.sv
// Scoreboard bench for perfc_multi: expected read data is queued at
// request time and compared when the bus response is sampled.
module tb_perfc_multi;

  logic clk = 1'b0;
  logic rst_n;
  reg_pkg::reg_req_t req;
  reg_pkg::reg_rsp_t rsp;
  logic [15:0] ev;
  logic intr;

  int n_chk = 0;
  int n_err = 0;

  logic [32:0] q_exp[$];
  string       q_tag[$];

  perfc_multi dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .reg_req_i(req),
    .reg_rsp_o(rsp),
    .events_i (ev),
    .intr_o   (intr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] a_cfg(int i);
    return 32'h20 + 32'h20 * i;
  endfunction
  function automatic logic [31:0] a_lo(int i);
    return a_cfg(i) + 32'h4;
  endfunction
  function automatic logic [31:0] a_hi(int i);
    return a_cfg(i) + 32'h8;
  endfunction
  function automatic logic [31:0] a_slo(int i);
    return a_cfg(i) + 32'hC;
  endfunction
  function automatic logic [31:0] a_shi(int i);
    return a_cfg(i) + 32'h10;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req.valid = 1'b1;
    req.write = 1'b1;
    req.addr = a;
    req.wdata = d;
    req.wstrb = 4'hF;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    req.write = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    logic [32:0] got;
    @(negedge clk);
    req.valid = 1'b1;
    req.write = 1'b0;
    req.addr = a;
    #1;
    got = {rsp.error, rsp.rdata};
    check(q_tag.pop_front(), 64'(got), 64'(q_exp.pop_front()));
    @(posedge clk);
    #1;
    req.valid = 1'b0;
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back({1'b0, exp});
    bus_rd(a);
  endtask

  task automatic rd_err(input string tag, input logic [31:0] a);
    q_tag.push_back(tag);
    q_exp.push_back({1'b1, 32'h0});
    bus_rd(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ev = '0;
    req = '0;
    #1;
    check("rst_rsp", 64'({rsp.ready, rsp.error, rsp.rdata}),
          64'({1'b1, 1'b0, 32'h0}));
    check("rst_intr", 64'(intr), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_exp("rst_ctrl", 32'h0, 32'h0);
    rd_exp("rst_ist", 32'h4, 32'h0);
    rd_exp("rst_cnt0", a_lo(0), 32'h0);

    // Level counting
    wr(32'h0, 32'h1);
    wr(a_cfg(0), 32'h301);
    rd_exp("cfg0_rb", a_cfg(0), 32'h301);
    @(negedge clk);
    ev[3] = 1'b1;
    repeat (10) @(negedge clk);
    ev[3] = 1'b0;
    rd_exp("lvl_lo", a_lo(0), 32'd10);
    rd_exp("lvl_hi", a_hi(0), 32'd0);
    rd_err("unmapped", 32'h400);
    rd_err("bad_idx", a_cfg(4));
    rd_err("bad_sub", a_cfg(0) + 32'h14);
    wr(a_lo(4), 32'h55);
    rd_exp("errwr_cnt0", a_lo(0), 32'd10);

    // Edge counting
    wr(a_cfg(1), 32'h503);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      ev[5] = 1'b1;
      @(negedge clk);
      ev[5] = 1'b0;
    end
    @(negedge clk);
    ev[5] = 1'b1;
    repeat (20) @(negedge clk);
    ev[5] = 1'b0;
    rd_exp("edge_lo", a_lo(1), 32'd8);

    // Wrap and interrupt
    wr(32'h0, 32'h0);
    wr(a_lo(2), 32'hFFFF_FFFE);
    wr(a_hi(2), 32'h0000_FFFF);
    wr(32'h8, 32'h4);
    wr(a_cfg(2), 32'h701);
    ev[7] = 1'b1;
    wr(32'h0, 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("pre_wrap_intr", 64'(intr), 64'(0));
    @(negedge clk);
    ev[7] = 1'b0;
    check("wrap_intr", 64'(intr), 64'(1));
    rd_exp("wrap_lo", a_lo(2), 32'h0);
    rd_exp("wrap_hi", a_hi(2), 32'h0);
    rd_exp("wrap_ist", 32'h4, 32'h4);
    wr(32'h4, 32'h4);
    check("w1c_intr", 64'(intr), 64'(0));
    rd_exp("w1c_ist", 32'h4, 32'h0);

    // Atomic split read while counting across the 32-bit boundary
    wr(32'h0, 32'h0);
    wr(a_lo(0), 32'hFFFF_FFFF);
    wr(a_hi(0), 32'h0);
    ev[3] = 1'b1;
    wr(32'h0, 32'h1);
    rd_exp("split_lo", a_lo(0), 32'hFFFF_FFFF);
    rd_exp("split_hi", a_hi(0), 32'h0);
    ev[3] = 1'b0;
    rd_exp("split_lo2", a_lo(0), 32'h1);
    rd_exp("split_hi2", a_hi(0), 32'h1);

    // Snapshot with clear; ch0 event high on that edge
    for (int i = 0; i < 4; i++) begin
      wr(a_lo(i), 32'(5 + i));
      wr(a_hi(i), 32'h0);
    end
    ev[3] = 1'b1;
    wr(32'h0, 32'h7);
    ev[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_exp($sformatf("snap_lo%0d", i), a_slo(i), 32'(5 + i));
      rd_exp($sformatf("snap_hi%0d", i), a_shi(i), 32'h0);
      rd_exp($sformatf("clr_cnt%0d", i), a_lo(i), 32'h0);
    end
    rd_exp("ctrl_gen", 32'h0, 32'h1);
    rd_exp("cfg2_kept", a_cfg(2), 32'h701);

    // Software write beats a same-cycle increment
    ev[3] = 1'b1;
    wr(a_lo(0), 32'h100);
    ev[3] = 1'b0;
    rd_exp("wr_wins", a_lo(0), 32'h100);

    // Wrap and W1C of the same bit in one cycle
    wr(32'h0, 32'h0);
    wr(a_lo(0), 32'hFFFF_FFFF);
    wr(a_hi(0), 32'h0000_FFFF);
    wr(32'h8, 32'h1);
    wr(32'h0, 32'h1);
    ev[3] = 1'b1;
    wr(32'h4, 32'h1);
    ev[3] = 1'b0;
    check("set_wins_intr", 64'(intr), 64'(1));
    rd_exp("set_wins_ist", 32'h4, 32'h1);
    rd_exp("wrap0_lo", a_lo(0), 32'h0);

    // Reset in the middle of counting
    ev[3] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_intr", 64'(intr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rd_exp("post_cnt0", a_lo(0), 32'h0);
    rd_exp("post_cfg0", a_cfg(0), 32'h0);
    rd_exp("post_ctrl", 32'h0, 32'h0);
    rd_exp("post_ist", 32'h4, 32'h0);
    rd_exp("post_ien", 32'h8, 32'h0);
    rd_exp("post_snap0", a_slo(0), 32'h0);
    ev[3] = 1'b0;
    check("post_intr", 64'(intr), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
